// File: rtl/tdm_demux_rx.sv
// Four-slot TDM receiver: frame alignment tracker, slot demultiplexer and a
// single-entry valid/ready output register with overrun detection.
module tdm_demux_rx #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic frame_sync,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic out_valid,
  input  logic out_ready,
  output logic locked,
  output logic sync_err,
  output logic overrun
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);
  // With a single-frame lock requirement any accepted sync locks immediately.
  localparam state_t RELOCK_STATE = (LOCK_FRAMES == 1) ? LOCKED : CHECK;

  state_t      state_q;
  logic [1:0]  slot_q;
  logic [2:0]  sh_q;
  logic [2:0]  good_q;
  logic [3:0]  y_q;
  logic        valid_q;
  logic        err_q;
  logic        ovr_q;

  logic [1:0]  slot_d;
  logic [2:0]  good_inc_d;
  logic [3:0]  word_d;
  logic        offer_d;

  // frame_sync overrides the prediction: that cycle is slot 0.
  assign slot_d     = frame_sync ? 2'd0 : slot_q;
  assign good_inc_d = (good_q == 3'd7) ? 3'd7 : good_q + 3'd1;
  assign word_d     = {sh_q[0], sh_q[1], sh_q[2], data_in};
  assign offer_d    = (state_q == LOCKED) && (slot_d == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q[gi] <= 1'b0;
        end else if (slot_d == 2'(gi)) begin
          sh_q[gi] <= data_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      good_q  <= 3'd0;
      y_q     <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      slot_q <= slot_d + 2'd1;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;

      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            good_q  <= 3'd1;
            state_q <= RELOCK_STATE;
          end
        end
        CHECK, LOCKED: begin
          if (frame_sync && (slot_q == 2'd0)) begin
            good_q <= good_inc_d;
            if ((state_q == CHECK) && (good_inc_d >= LOCK_N)) begin
              state_q <= LOCKED;
            end
          end else if (frame_sync) begin
            err_q   <= 1'b1;
            good_q  <= 3'd1;
            state_q <= RELOCK_STATE;
          end else if (slot_q == 2'd0) begin
            err_q   <= 1'b1;
            good_q  <= 3'd0;
            state_q <= HUNT;
          end
        end
        default: begin
          state_q <= HUNT;
          good_q  <= 3'd0;
        end
      endcase

      // A word offered while the held word is stalled is lost, not queued.
      if (offer_d) begin
        if (!valid_q || out_ready) begin
          y_q     <= word_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Y0        = y_q[3];
  assign Y1        = y_q[2];
  assign Y2        = y_q[1];
  assign Y3        = y_q[0];
  assign out_valid = valid_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (LOCK_FRAMES=2): lock acquisition, streaming,
// overrun, misplaced/missing sync and mid-frame reset.
module tb_tdm_demux_rx;

  logic clk = 1'b0;
  logic rst, data_in, frame_sync, out_ready;
  logic Y0, Y1, Y2, Y3, out_valid, locked, sync_err, overrun;
  logic [3:0] ys;

  int n_tests = 0;
  int n_fail  = 0;

  logic       seen_ov, seen_err, valid_dropped;
  logic [3:0] y_mid;

  always #5 clk = ~clk;

  assign ys = {Y0, Y1, Y2, Y3};

  tdm_demux_rx #(.LOCK_FRAMES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .frame_sync(frame_sync),
    .Y0        (Y0),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .sync_err  (sync_err),
    .overrun   (overrun)
  );

  task automatic step(input logic fs, input logic d, input logic rdy);
    frame_sync = fs;
    data_in    = d;
    out_ready  = rdy;
    @(posedge clk);
    #1;
    seen_ov  = seen_ov | overrun;
    seen_err = seen_err | sync_err;
    if (out_valid !== 1'b1) valid_dropped = 1'b1;
  endtask

  // b[3] is the slot-0 bit; rdy[3] is out_ready during the slot-0 cycle.
  task automatic send_frame(input logic sync, input logic [3:0] b, input logic [3:0] rdy);
    for (int k = 0; k < 4; k++) begin
      step((k == 0) && sync, b[3-k], rdy[3-k]);
      if (k == 2) y_mid = ys;
    end
  endtask

  task automatic clear_flags();
    seen_ov       = 1'b0;
    seen_err      = 1'b0;
    valid_dropped = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({ys, out_valid, locked, sync_err, overrun} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got Y=%b v=%b l=%b e=%b o=%b expected all 0",
               ys, out_valid, locked, sync_err, overrun);
    end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_lock();
    clear_flags();
    send_frame(1'b1, 4'b1011, 4'b1111);
    n_tests++;
    if ({locked, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL lock_frame1: got locked=%b valid=%b expected 0 0", locked, out_valid);
    end
    step(1'b1, 1'b1, 1'b1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_rise: got locked=%b expected 1", locked);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_latency: got valid=%b at slot 2 expected 0", out_valid);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({out_valid, ys} !== 5'b1_1011) begin
      n_fail++;
      $display("FAIL lock_first_word: got valid=%b Y=%b expected 1 1011", out_valid, ys);
    end
    $display("[TB] test_lock done Y=%b", ys);
  endtask

  task automatic test_back_to_back();
    clear_flags();
    send_frame(1'b1, 4'b0101, 4'b0001);
    n_tests++;
    if ({valid_dropped, seen_ov, y_mid, ys} !== {2'b00, 4'b1011, 4'b0101}) begin
      n_fail++;
      $display("FAIL stream_0101: got drop=%b ov=%b ymid=%b Y=%b expected 0 0 1011 0101",
               valid_dropped, seen_ov, y_mid, ys);
    end
    send_frame(1'b1, 4'b1110, 4'b0001);
    n_tests++;
    if ({valid_dropped, seen_ov, seen_err, y_mid, ys} !== {3'b000, 4'b0101, 4'b1110}) begin
      n_fail++;
      $display("FAIL stream_1110: got drop=%b ov=%b err=%b ymid=%b Y=%b expected 0 0 0 0101 1110",
               valid_dropped, seen_ov, seen_err, y_mid, ys);
    end
    $display("[TB] test_back_to_back done Y=%b", ys);
  endtask

  task automatic test_overrun();
    clear_flags();
    send_frame(1'b1, 4'b0011, 4'b0000);
    n_tests++;
    if ({overrun, out_valid, ys} !== 6'b11_1110) begin
      n_fail++;
      $display("FAIL overrun_pulse: got ov=%b valid=%b Y=%b expected 1 1 1110", overrun, out_valid, ys);
    end
    step(1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({overrun, out_valid, ys} !== 6'b00_1110) begin
      n_fail++;
      $display("FAIL overrun_clear: got ov=%b valid=%b Y=%b expected 0 0 1110", overrun, out_valid, ys);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({out_valid, ys} !== 5'b0_1110) begin
      n_fail++;
      $display("FAIL idle_hold: got valid=%b Y=%b expected 0 1110", out_valid, ys);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({out_valid, ys} !== 5'b1_1001) begin
      n_fail++;
      $display("FAIL after_overrun_word: got valid=%b Y=%b expected 1 1001", out_valid, ys);
    end
    $display("[TB] test_overrun done Y=%b", ys);
  endtask

  task automatic test_misplaced_sync();
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({sync_err, locked} !== 2'b10) begin
      n_fail++;
      $display("FAIL misplaced_err: got err=%b locked=%b expected 1 0", sync_err, locked);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL misplaced_pulse_len: got err=%b expected 0", sync_err);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL check_no_word: got valid=%b expected 0", out_valid);
    end
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got locked=%b expected 1", locked);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({out_valid, ys} !== 5'b1_0110) begin
      n_fail++;
      $display("FAIL relock_word: got valid=%b Y=%b expected 1 0110", out_valid, ys);
    end
    $display("[TB] test_misplaced_sync done Y=%b", ys);
  endtask

  task automatic test_missing_sync();
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({sync_err, locked} !== 2'b10) begin
      n_fail++;
      $display("FAIL missing_err: got err=%b locked=%b expected 1 0", sync_err, locked);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_pulse_len: got err=%b expected 0", sync_err);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({out_valid, locked, ys} !== 6'b00_0110) begin
      n_fail++;
      $display("FAIL hunt_no_word: got valid=%b locked=%b Y=%b expected 0 0 0110", out_valid, locked, ys);
    end
    $display("[TB] test_missing_sync done");
  endtask

  task automatic test_midframe_reset();
    send_frame(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({locked, out_valid, ys} !== 6'b11_1100) begin
      n_fail++;
      $display("FAIL prereset_word: got locked=%b valid=%b Y=%b expected 1 1 1100", locked, out_valid, ys);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    n_tests++;
    if ({ys, out_valid, locked, sync_err, overrun} !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outputs: got Y=%b v=%b l=%b e=%b o=%b expected all 0",
               ys, out_valid, locked, sync_err, overrun);
    end
    send_frame(1'b1, 4'b1010, 4'b0000);
    n_tests++;
    if ({locked, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL postreset_one_sync: got locked=%b valid=%b expected 0 0", locked, out_valid);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({locked, out_valid, ys} !== 6'b11_0111) begin
      n_fail++;
      $display("FAIL postreset_word: got locked=%b valid=%b Y=%b expected 1 1 0111", locked, out_valid, ys);
    end
    $display("[TB] test_midframe_reset done Y=%b", ys);
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = 1'b0;
    frame_sync = 1'b0;
    out_ready  = 1'b0;
    clear_flags();
    y_mid = 4'd0;
    test_reset();
    test_lock();
    test_back_to_back();
    test_overrun();
    test_misplaced_sync();
    test_missing_sync();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
